psum_drain_buffer: RTL and testbench



---
 rtl/psum_drain_buffer.sv | 246 ++++++++++++++++++++++++
 tb/tb_psum_drain_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_buffer.sv
// psum_drain_buffer
// Collects the skewed column psums leaving the bottom of the 16x16 systolic
// array, rebuilds them into row order, requantizes each psum to signed int8
// and writes packed 4-byte words to memory over a valid/ready port.
// Pulses done when the tile is fully written so the controller can move on.
//
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative psums to zero
// before the shift (output range 0..127). Left undefined, results keep their
// sign and use the full int8 range.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; configuration latched on start
// S_CAPTR | de-skewing column psums into the row buffer
// S_DRAIN | presenting packed int8 words on the memory write port
// S_DONE  | done pulse, then back to idle

module psum_drain_buffer #(
  parameter int ARRAY_SIZE = 16,
  parameter int PSUM_W     = 24,
  parameter int DEPTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [31:0]                  base_addr,
  input  logic [$clog2(DEPTH):0]       row_count,
  input  logic [4:0]                   shift,
  input  logic                         psum_valid,
  input  logic [ARRAY_SIZE*PSUM_W-1:0] flat_psum_in,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  mem_write_addr,
  output logic [31:0]                  mem_write_data,
  output logic                         mem_write_valid,
  input  logic                         mem_write_ready
);

  localparam int RC_W  = $clog2(DEPTH) + 1;
  localparam int ROW_W = $clog2(DEPTH);
  localparam int GPR   = ARRAY_SIZE / 4;
  localparam int GRP_W = (GPR > 1) ? $clog2(GPR) : 1;

  localparam logic [GRP_W-1:0]         GRP_LAST  = GRP_W'(GPR - 1);
  localparam logic [RC_W-1:0]          ROWS_MAX  = RC_W'(DEPTH);
  localparam logic [4:0]               SHIFT_MAX = 5'd23;
  localparam logic signed [PSUM_W-1:0] SAT_HI    = PSUM_W'(127);
  localparam logic signed [PSUM_W-1:0] SAT_LO    = PSUM_W'(-128);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CAPTR = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_base;
  logic [4:0]              r_shift;
  logic [RC_W-1:0]         r_rows;
  logic [RC_W-1:0]         r_col_ptr [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:1]   r_vld_dly;
  logic [ROW_W-1:0]        r_row;
  logic [GRP_W-1:0]        r_grp;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_wvalid;
  logic [31:0]             r_waddr;
  logic [31:0]             r_wdata;

  // Row buffer is not reset: the column pointers alone say which entries are live.
  logic [PSUM_W-1:0]       r_buf [DEPTH][ARRAY_SIZE];

  logic                    w_cap;
  logic [ARRAY_SIZE-1:0]   w_vld;
  logic [ARRAY_SIZE-1:0]   w_we;
  logic [PSUM_W-1:0]       w_col [ARRAY_SIZE];
  logic                    w_last_cap;
  logic                    w_hs;
  logic                    w_last_word;
  logic [ROW_W-1:0]        w_nxt_row;
  logic [GRP_W-1:0]        w_nxt_grp;
  logic [31:0]             w_nxt_data;
  logic [PSUM_W-1:0]       w_elem;

  // Requantize one psum: optional ReLU, arithmetic shift (floor), int8 saturation.
  function automatic logic [7:0] f_requant(input logic [PSUM_W-1:0] psum,
                                           input logic [4:0]        sh);
    logic signed [PSUM_W-1:0] v_x;
    logic signed [PSUM_W-1:0] v_y;
    logic [7:0]               v_q;
    v_x = signed'(psum);
`ifdef PSUM_DRAIN_RELU_EN
    if (v_x[PSUM_W-1]) v_x = '0;
`endif
    v_y = v_x >>> sh;
    if (v_y > SAT_HI)      v_q = 8'h7f;
    else if (v_y < SAT_LO) v_q = 8'h80;
    else                   v_q = v_y[7:0];
    return v_q;
  endfunction

  assign busy            = r_busy;
  assign done            = r_done;
  assign mem_write_addr  = r_waddr;
  assign mem_write_data  = r_wdata;
  assign mem_write_valid = r_wvalid;

  assign w_cap = (r_state == S_CAPTR);
  assign w_hs  = r_wvalid && mem_write_ready;

  // Column j sees psum_valid delayed by j cycles; column 0 is the live input.
  assign w_vld = {r_vld_dly, psum_valid && w_cap};

  // Split the flat bus into columns and decide which columns store this cycle.
  always_comb begin
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      w_col[c] = flat_psum_in[c*PSUM_W +: PSUM_W];
      w_we[c]  = w_cap && w_vld[c] && (r_col_ptr[c] < r_rows);
    end
  end

  assign w_last_cap  = w_we[ARRAY_SIZE-1] &&
                       (r_col_ptr[ARRAY_SIZE-1] == r_rows - 1'b1);
  assign w_last_word = (RC_W'(r_row) == r_rows - 1'b1) && (r_grp == GRP_LAST);

  // Word position that follows the one being presented (first word on CAPTURE exit).
  always_comb begin
    w_nxt_row = '0;
    w_nxt_grp = '0;
    if (r_state == S_DRAIN) begin
      if (r_grp == GRP_LAST) begin
        w_nxt_row = r_row + 1'b1;
      end else begin
        w_nxt_row = r_row;
        w_nxt_grp = r_grp + 1'b1;
      end
    end
  end

  // Pack the next word; an element being captured this very cycle is forwarded
  // from the input so the first word can be formed on the CAPTURE exit edge.
  always_comb begin
    w_nxt_data = '0;
    w_elem     = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (GRP_W'(c / 4) == w_nxt_grp) begin
        if (w_we[c] && (r_col_ptr[c][ROW_W-1:0] == w_nxt_row))
          w_elem = w_col[c];
        else
          w_elem = r_buf[w_nxt_row][c];
        w_nxt_data[8*(c%4) +: 8] = f_requant(w_elem, r_shift);
      end
    end
  end

  // Row buffer write: column j lands at the row its own pointer names.
  always_ff @(posedge clk) begin
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (w_we[c])
        r_buf[r_col_ptr[c][ROW_W-1:0]][c] <= w_col[c];
    end
  end

  // Sequencer: configuration latch, de-skew pointers, drain handshake, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_shift   <= '0;
      r_rows    <= '0;
      r_vld_dly <= '0;
      r_row     <= '0;
      r_grp     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wvalid  <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      for (int c = 0; c < ARRAY_SIZE; c++) r_col_ptr[c] <= '0;
    end else begin
      r_vld_dly <= w_vld[ARRAY_SIZE-2:0];
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        if (w_we[c]) r_col_ptr[c] <= r_col_ptr[c] + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base    <= base_addr;
            r_shift   <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
            r_rows    <= (row_count > ROWS_MAX) ? ROWS_MAX : row_count;
            r_vld_dly <= '0;
            for (int c = 0; c < ARRAY_SIZE; c++) r_col_ptr[c] <= '0;
            if (row_count == '0) begin
              // Empty tile: DONE spends one quiet cycle before the pulse.
              r_state <= S_DONE;
            end else begin
              r_state <= S_CAPTR;
              r_busy  <= 1'b1;
            end
          end
        end

        S_CAPTR: begin
          if (w_last_cap) begin
            r_state  <= S_DRAIN;
            r_wvalid <= 1'b1;
            r_waddr  <= r_base;
            r_wdata  <= w_nxt_data;
            r_row    <= '0;
            r_grp    <= '0;
          end
        end

        S_DRAIN: begin
          if (w_hs) begin
            if (w_last_word) begin
              r_wvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_waddr <= r_waddr + 32'd4;
              r_wdata <= w_nxt_data;
              r_row   <= w_nxt_row;
              r_grp   <= w_nxt_grp;
            end
          end
        end

        S_DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain_buffer.sv
// Directed bench for psum_drain_buffer: drives skewed column psums, predicts
// the memory image from the requantization rules, and checks every write.

module tb_psum_drain_buffer;

  localparam int N = 16;
  localparam int W = 24;
  localparam int D = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    base_addr = '0;
  logic [5:0]     row_count = '0;
  logic [4:0]     shift = '0;
  logic           psum_valid = 1'b0;
  logic [N*W-1:0] flat_psum_in = '0;
  logic           busy;
  logic           done;
  logic [31:0]    mem_write_addr;
  logic [31:0]    mem_write_data;
  logic           mem_write_valid;
  logic           mem_write_ready = 1'b1;

  psum_drain_buffer #(.ARRAY_SIZE(N), .PSUM_W(W), .DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .row_count       (row_count),
    .shift           (shift),
    .psum_valid      (psum_valid),
    .flat_psum_in    (flat_psum_in),
    .busy            (busy),
    .done            (done),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_valid (mem_write_valid),
    .mem_write_ready (mem_write_ready)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          ps [D][N];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          hs_count = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] first_data = '0;
  logic [31:0] last_addr = '0;
  bit          rnd_ready = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference requantization using integer division rather than shifts.
  function automatic logic [7:0] ref_q(input int p_in, input int sh);
    int s, d, q, p;
    p = p_in;
`ifdef PSUM_DRAIN_RELU_EN
    if (p < 0) p = 0;
`endif
    s = (sh > 23) ? 23 : sh;
    d = 1 << s;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic logic [31:0] ref_word(input int r, input int g, input int sh);
    return {ref_q(ps[r][4*g+3], sh), ref_q(ps[r][4*g+2], sh),
            ref_q(ps[r][4*g+1], sh), ref_q(ps[r][4*g],   sh)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    mem_write_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Compare process: every accepted write against the predicted image, plus
  // address/data stability while a request is stalled.
  initial begin
    bit          held;
    logic [31:0] h_addr, h_data;
    held = 1'b0;
    h_addr = '0;
    h_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid_held", 32'(mem_write_valid), 32'd1);
          check("stall_addr_stable", mem_write_addr, h_addr);
          check("stall_data_stable", mem_write_data, h_data);
        end
        if (mem_write_valid) check("busy_while_valid", 32'(busy), 32'd1);
        held   = mem_write_valid && !mem_write_ready;
        h_addr = mem_write_addr;
        h_data = mem_write_data;
        if (mem_write_valid && mem_write_ready) begin
          if (exp_addr.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none required",
                     mem_write_addr, mem_write_data);
          end else begin
            check("wr_addr", mem_write_addr, exp_addr.pop_front());
            check("wr_data", mem_write_data, exp_data.pop_front());
          end
          if (hs_count == 0) begin
            first_addr   = mem_write_addr;
            first_data   = mem_write_data;
            first_hs_cyc = cyc;
          end
          last_addr   = mem_write_addr;
          last_hs_cyc = cyc;
          hs_count++;
        end
      end
    end
  end

  task automatic run_tile(input logic [31:0] base, input int rows_cfg, input int sh,
                          input int gap, input bit rnd, input bit spur, input bit abort_it);
    int rows, per, t_last, done_cyc;
    bit got;
    rows = (rows_cfg > D) ? D : rows_cfg;
    per  = gap + 1;
    for (int r = 0; r < rows; r++)
      for (int g = 0; g < N/4; g++) begin
        exp_addr.push_back(base + 32'(4*(r*(N/4)+g)));
        exp_data.push_back(ref_word(r, g, sh));
      end
    hs_count  = 0;
    rnd_ready = rnd;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    row_count = 6'(rows_cfg);
    shift     = 5'(sh);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rises_after_start", 32'(busy), 32'd1);
    t_last = (rows-1)*per + N-1;
    for (int t = 0; t <= t_last; t++) begin
      psum_valid = ((t % per) == 0) && ((t / per) < rows);
      for (int j = 0; j < N; j++) begin
        if (t >= j && ((t-j) % per) == 0 && ((t-j) / per) < rows)
          flat_psum_in[j*W +: W] = W'(ps[(t-j)/per][j]);
        else
          flat_psum_in[j*W +: W] = 24'h5a5a5a;
      end
      if (spur && t == 5) begin
        start = 1'b1; base_addr = 32'h9999_0000; row_count = 6'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    start      = 1'b0;
    if (spur) begin
      start = 1'b1; base_addr = 32'h7777_0000; row_count = 6'd2; shift = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (abort_it) begin
      for (int i = 0; i < 500 && hs_count < 5; i++) @(posedge clk);
      check("abort_point_reached", 32'(hs_count >= 5), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid_low", 32'(mem_write_valid), 32'd0);
      check("abort_busy_low", 32'(busy), 32'd0);
      check("abort_addr_zero", mem_write_addr, 32'd0);
      exp_addr.delete();
      exp_data.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rnd_ready = 1'b0;
      return;
    end
    got = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("done_after_last_write", 32'(done_cyc), 32'(last_hs_cyc + 1));
      check("busy_low_at_done", 32'(busy), 32'd0);
      check("words_outstanding", 32'(exp_addr.size()), 32'd0);
      @(negedge clk);
      check("done_single_cycle", 32'(done), 32'd0);
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) ps[r][c] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(mem_write_valid), 32'd0);
    check("rst_addr", mem_write_addr, 32'd0);
    check("rst_data", mem_write_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model against hand-computed values
`ifdef PSUM_DRAIN_RELU_EN
    check("model_neg300_sh0", 32'(ref_q(-300, 0)), 32'h00);
    check("model_neg300_sh4", 32'(ref_q(-300, 4)), 32'h00);
    check("model_neg5", 32'(ref_q(-5, 0)), 32'h00);
`else
    check("model_neg300_sh0", 32'(ref_q(-300, 0)), 32'h80);
    check("model_neg300_sh4", 32'(ref_q(-300, 4)), 32'hED);
    check("model_neg5", 32'(ref_q(-5, 0)), 32'hFB);
`endif
    check("model_70000_sh0", 32'(ref_q(70000, 0)), 32'h7F);
    check("model_70000_sh4", 32'(ref_q(70000, 4)), 32'h7F);

    // Contiguous 4 rows, psum = r*16+c
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < N; c++) ps[r][c] = r*16 + c;
    check("model_word0", ref_word(0, 0, 0), 32'h03020100);
    run_tile(32'h1000, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t1_word_count", 32'(hs_count), 32'd16);
    check("t1_first_addr", first_addr, 32'h1000);
    check("t1_first_data", first_data, 32'h03020100);
    check("t1_last_addr", last_addr, 32'h103C);
    check("t1_first_write_cycle", 32'(first_hs_cyc), 32'(start_cyc + 20));
    check("t1_one_word_per_cycle", 32'(last_hs_cyc - first_hs_cyc), 32'd15);

    // Same rows with 3-cycle gaps between rows
    run_tile(32'h1000, 2, 0, 3, 1'b0, 1'b0, 1'b0);
    check("gap_word_count", 32'(hs_count), 32'd8);

    // Saturation and shift
    ps[0][0] = -300;
    ps[0][1] = 70000;
    ps[0][2] = -8388608;
    ps[0][3] = 8388607;
    for (int c = 4; c < N; c++) ps[0][c] = c*1000 - 9000;
    run_tile(32'h2000, 1, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef PSUM_DRAIN_RELU_EN
    check("sat_sh0_bytes", {16'h0, first_data[15:0]}, 32'h7F00);
`else
    check("sat_sh0_bytes", {16'h0, first_data[15:0]}, 32'h7F80);
`endif
    run_tile(32'h2100, 1, 4, 0, 1'b0, 1'b0, 1'b0);
`ifdef PSUM_DRAIN_RELU_EN
    check("sat_sh4_bytes", {16'h0, first_data[15:0]}, 32'h7F00);
`else
    check("sat_sh4_bytes", {16'h0, first_data[15:0]}, 32'h7FED);
`endif
    run_tile(32'h2200, 1, 31, 0, 1'b0, 1'b0, 1'b0);

    // Full-depth random tile: row_count clamp, random ready, start while busy
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) ps[r][c] = int'($urandom_range(16777215, 0)) - 8388608;
    run_tile(32'h4000, 40, 2, 0, 1'b1, 1'b1, 1'b0);
    check("clamp_word_count", 32'(hs_count), 32'd128);

    // row_count == 0: no writes, done two cycles after start
    hs_count = 0;
    @(posedge clk); #1;
    start = 1'b1; row_count = 6'd0; base_addr = 32'h6000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rc0_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      check("rc0_busy", 32'(busy), 32'd0);
      if (i == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("rc0_no_writes", 32'(hs_count), 32'd0);

    // Reset in the middle of DRAIN, then a clean tile
    run_tile(32'h5000, 4, 1, 0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < N; c++) ps[0][c] = c;
    ps[0][0] = -5;
    run_tile(32'h5800, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("post_reset_first_addr", first_addr, 32'h5800);
`ifdef PSUM_DRAIN_RELU_EN
    check("post_reset_byte0", {24'h0, first_data[7:0]}, 32'h00);
`else
    check("post_reset_byte0", {24'h0, first_data[7:0]}, 32'hFB);
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
